uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit half of the board's serial link: accepts bytes from upstream logic into a small FIFO and serializes them onto the TX pin as 8N1 UART frames at a fixed bit period. It sits between the game-controller logic and the FPGA TX pin, and pairs with the existing receiver at the same baud rate. Frames are sent back-to-back while the FIFO holds data. Completion of each frame is reported with a one-cycle pulse.

## Interface
- c_CYCLES_PER_BIT, 217, clock cycles per serial bit (25 MHz / 115200); legal range ≥ 2.
- c_FIFO_ADDR_W, 2, FIFO address width; depth = 2^c_FIFO_ADDR_W (default 4 bytes).
- i_CLK  input  1  system clock; all logic on rising edge.
- i_RESET  input  1  synchronous, active-high reset.
- i_TX_DV  input  1  write strobe; byte on i_DATA_TX is pushed when i_TX_DV=1 and o_TX_READY=1.
- i_DATA_TX  input  8  byte to transmit.
- o_TX_READY  output  1  FIFO not full (combinational from registered count).
- o_SERIAL_DATA  output  1  registered serial line; idle high.
- o_TX_ACTIVE  output  1  high while a frame (start through stop) is on the line.
- o_TX_DONE  output  1  one-cycle pulse on the last cycle of each stop bit.
- o_FIFO_COUNT  output  c_FIFO_ADDR_W+1  bytes currently queued (0..depth).

## Operation
- FIFO: circular buffer with read/write pointers of width c_FIFO_ADDR_W and a count of width c_FIFO_ADDR_W+1; pointers wrap modulo depth.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Push while full: ignored (o_TX_READY=0); data dropped; count unchanged. There is no same-cycle bypass of a full FIFO, even when a pop occurs in that cycle.
- Pop from empty: never occurs; the FSM pops only when count ≠ 0.
- FSM states:
  - IDLE: line high, o_TX_ACTIVE=0. If count ≠ 0: pop head into shift register, clear bit counter, go to START.
  - START: line low for c_CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line = shift[bit index], LSB first; each bit lasts c_CYCLES_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: line high for c_CYCLES_PER_BIT cycles. On the last cycle, o_TX_DONE=1. Next state: if count ≠ 0, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Cycle counter: width $clog2(c_CYCLES_PER_BIT); counts 0..c_CYCLES_PER_BIT−1, then wraps to 0 on every bit boundary.
- The byte is captured into the shift register at pop time. Later FIFO writes never alter a frame in flight.
- Unused/illegal state encodings go to IDLE.

## Timing
- Reset values: o_SERIAL_DATA=1, o_TX_ACTIVE=0, o_TX_DONE=0, o_FIFO_COUNT=0, o_TX_READY=1; FIFO pointers 0; FSM in IDLE.
- Reset mid-frame: on the next edge the line is high, the FIFO is flushed, and no o_TX_DONE pulse is issued.
- Latency, idle and empty FIFO:
  - Push accepted at edge N; count=1 after edge N.
  - FSM pops at edge N+1; o_SERIAL_DATA=0 and o_TX_ACTIVE=1 from edge N+1.
- Frame length: exactly 10·c_CYCLES_PER_BIT cycles from the first start-bit cycle to the end of the stop bit.
- o_TX_DONE is high for exactly one cycle, coincident with the final stop-bit cycle.
- Back-to-back frames: the next start bit begins on the cycle immediately after that pulse cycle.
- o_TX_ACTIVE stays high across back-to-back frames. It falls on the cycle after o_TX_DONE only when the FIFO is empty.
- o_TX_READY reflects the count after the previous edge. Upstream may hold i_TX_DV high; one byte is pushed per cycle while ready.

## Test plan
- Reset, no stimulus: o_SERIAL_DATA=1, o_TX_READY=1, o_FIFO_COUNT=0, o_TX_DONE never pulses over 200 cycles.
- Single byte (c_CYCLES_PER_BIT=4): push 0xA5 into an idle block.
  - Line reads 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles; 40 cycles total.
  - Exactly one o_TX_DONE pulse, on cycle 40.
  - o_TX_ACTIVE falls on the next cycle.
- Back-to-back frames: push 0x00, 0xFF, 0x3C on consecutive cycles.
  - Three contiguous frames with no idle gap; start bits at cycles 1, 41, 81 after the first push.
  - Three o_TX_DONE pulses; o_TX_ACTIVE stays continuously high for 120 cycles.
- Full FIFO (depth 4): hold i_TX_DV high with bytes 0x01..0x06 on consecutive cycles while idle.
  - The first pop occurs on cycle 2, so 0x01–0x05 are accepted and 0x06 is dropped.
  - o_TX_READY=0 while count=4; exactly five frames are transmitted, in order.
- Simultaneous push and pop: with count=1 and STOP in its final cycle, push 0x77.
  - Count stays 1, pointers advance, and the next frame carries the older byte.
- Reset at mid-DATA bit 3: line high on the next edge; count=0.
  - No o_TX_DONE pulse; a new push afterwards transmits correctly.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO.
// Frames go out back-to-back while bytes are queued.
module uart_tx_fifo #(
    parameter int c_CYCLES_PER_BIT = 217,
    parameter int c_FIFO_ADDR_W    = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RESET,
    input  logic                     i_TX_DV,
    input  logic [7:0]               i_DATA_TX,
    output logic                     o_TX_READY,
    output logic                     o_SERIAL_DATA,
    output logic                     o_TX_ACTIVE,
    output logic                     o_TX_DONE,
    output logic [c_FIFO_ADDR_W:0]   o_FIFO_COUNT
);
    localparam int DEPTH = 1 << c_FIFO_ADDR_W;
    localparam int CNTW  = c_FIFO_ADDR_W + 1;
    localparam int CW    = (c_CYCLES_PER_BIT > 1) ? $clog2(c_CYCLES_PER_BIT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(c_CYCLES_PER_BIT - 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_n;

    logic [7:0]               mem [DEPTH];
    logic [c_FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0]          count;
    logic [CW-1:0]            cyc, cyc_n;
    logic [2:0]               bit_idx, bit_n;
    logic [7:0]               shift, shift_n;
    logic                     line_n;
    logic                     push, pop, last;

    assign o_TX_READY   = (count != FULL);
    assign o_FIFO_COUNT = count;
    assign o_TX_ACTIVE  = (state != IDLE);
    assign push         = i_TX_DV & o_TX_READY;
    assign last         = (cyc == LAST);

    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        bit_n     = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        o_TX_DONE = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                cyc_n = last ? '0 : cyc + 1'b1;
                if (last) begin
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                cyc_n = last ? '0 : cyc + 1'b1;
                if (last) begin
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_n   = bit_idx + 1'b1;
                end
            end
            STOP: begin
                cyc_n = last ? '0 : cyc + 1'b1;
                if (last) begin
                    o_TX_DONE = 1'b1;
                    // Zero-gap chaining: pop the next byte straight into START.
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        bit_n   = '0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift_n[bit_n];
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state         <= IDLE;
            cyc           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_SERIAL_DATA <= 1'b1;
        end else begin
            state         <= state_n;
            cyc           <= cyc_n;
            bit_idx       <= bit_n;
            shift         <= shift_n;
            o_SERIAL_DATA <= line_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) mem[wr_ptr] <= i_DATA_TX;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes,
// a line monitor decodes each frame and checks it against the queue.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic       i_CLK = 1'b0;
    logic       i_RESET = 1'b1;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_DATA_TX = 8'h00;
    logic       o_TX_READY, o_SERIAL_DATA, o_TX_ACTIVE, o_TX_DONE;
    logic [2:0] o_FIFO_COUNT;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_at = -1;
    int act_cnt = 0;
    int frames = 0;
    logic [7:0] sb[$];
    int starts[$];

    uart_tx_fifo #(
        .c_CYCLES_PER_BIT(CPB),
        .c_FIFO_ADDR_W(2)
    ) dut (
        .i_CLK(i_CLK),
        .i_RESET(i_RESET),
        .i_TX_DV(i_TX_DV),
        .i_DATA_TX(i_DATA_TX),
        .o_TX_READY(o_TX_READY),
        .o_SERIAL_DATA(o_SERIAL_DATA),
        .o_TX_ACTIVE(o_TX_ACTIVE),
        .o_TX_DONE(o_TX_DONE),
        .o_FIFO_COUNT(o_FIFO_COUNT)
    );

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) cyc <= cyc + 1;

    always @(negedge i_CLK) begin
        if (o_TX_DONE === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_at  <= cyc;
        end
        if (o_TX_ACTIVE === 1'b1) act_cnt <= act_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b, input bit accepted);
        i_TX_DV   = 1'b1;
        i_DATA_TX = b;
        if (accepted) sb.push_back(b);
        tick(1);
        i_TX_DV = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 3000 && !(sb.size() == 0 && o_TX_ACTIVE === 1'b0
                             && o_FIFO_COUNT == 3'd0)) begin
            tick(1);
            n++;
        end
        chk({name, "_drain"}, int'(n < 3000), 1);
    endtask

    // Line monitor: decodes one 8N1 frame per falling start edge.
    initial begin : monitor
        logic [7:0] d;
        bit ok;
        bit ab;
        int t0;
        forever begin
            @(negedge i_CLK);
            if (i_RESET === 1'b0 && o_SERIAL_DATA === 1'b0) begin
                ok = 1'b1;
                ab = 1'b0;
                d  = 8'h00;
                t0 = cyc;
                if (o_TX_ACTIVE !== 1'b1) ok = 1'b0;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge i_CLK);
                    ab |= i_RESET;
                    if (o_SERIAL_DATA !== 1'b0 || o_TX_ACTIVE !== 1'b1) ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge i_CLK);
                        ab |= i_RESET;
                        if (o_TX_ACTIVE !== 1'b1 || o_TX_DONE !== 1'b0) ok = 1'b0;
                        if (c == 0) d[b] = o_SERIAL_DATA;
                        else if (o_SERIAL_DATA !== d[b]) ok = 1'b0;
                    end
                end
                for (int c = 0; c < CPB; c++) begin
                    @(negedge i_CLK);
                    ab |= i_RESET;
                    if (o_SERIAL_DATA !== 1'b1 || o_TX_ACTIVE !== 1'b1) ok = 1'b0;
                    if (o_TX_DONE !== (c == CPB - 1)) ok = 1'b0;
                end
                if (!ab) begin
                    starts.push_back(t0);
                    frames++;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL frame_unexpected: got 0x%02h expected none", d);
                    end else begin
                        chk("frame_byte", int'(d), int'(sb.pop_front()));
                        chk("frame_shape", int'(ok), 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, d0, a0, f0;
        bit hi;

        // Reset state and quiet idle line
        tick(3);
        i_RESET = 1'b0;
        tick(1);
        chk("rst_line",   int'(o_SERIAL_DATA), 1);
        chk("rst_ready",  int'(o_TX_READY), 1);
        chk("rst_count",  int'(o_FIFO_COUNT), 0);
        chk("rst_active", int'(o_TX_ACTIVE), 0);
        chk("rst_done",   int'(o_TX_DONE), 0);
        d0 = done_cnt;
        hi = 1'b1;
        repeat (200) begin
            tick(1);
            if (o_SERIAL_DATA !== 1'b1) hi = 1'b0;
        end
        chk("idle_done", done_cnt - d0, 0);
        chk("idle_line", int'(hi), 1);

        // Single byte 0xA5
        d0 = done_cnt;
        a0 = act_cnt;
        push(8'hA5, 1'b1);
        n = cyc;
        chk("single_count", int'(o_FIFO_COUNT), 1);
        chk("single_pre_line", int'(o_SERIAL_DATA), 1);
        chk("single_pre_act", int'(o_TX_ACTIVE), 0);
        tick(1);
        chk("single_start_line", int'(o_SERIAL_DATA), 0);
        chk("single_start_act", int'(o_TX_ACTIVE), 1);
        chk("single_popped", int'(o_FIFO_COUNT), 0);
        wait_idle("single");
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_done_at", done_at, n + 40);
        chk("single_start_at", starts[starts.size() - 1], n + 1);
        chk("single_active_len", act_cnt - a0, 40);

        // Back-to-back 0x00, 0xFF, 0x3C
        d0 = done_cnt;
        a0 = act_cnt;
        push(8'h00, 1'b1);
        n = cyc;
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        wait_idle("b2b");
        chk("b2b_done_cnt", done_cnt - d0, 3);
        chk("b2b_start0", starts[starts.size() - 3], n + 1);
        chk("b2b_start1", starts[starts.size() - 2], n + 41);
        chk("b2b_start2", starts[starts.size() - 1], n + 81);
        chk("b2b_active_len", act_cnt - a0, 120);

        // Full FIFO: 0x01..0x05 accepted, 0x06 dropped
        f0 = frames;
        push(8'h01, 1'b1);
        push(8'h02, 1'b1);
        push(8'h03, 1'b1);
        push(8'h04, 1'b1);
        push(8'h05, 1'b1);
        chk("full_count", int'(o_FIFO_COUNT), 4);
        chk("full_ready", int'(o_TX_READY), 0);
        push(8'h06, 1'b0);
        chk("full_drop_count", int'(o_FIFO_COUNT), 4);
        wait_idle("full");
        chk("full_frames", frames - f0, 5);

        // Push coincident with the STOP-final pop
        f0 = frames;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        n = 0;
        while (n < 100 && o_TX_DONE !== 1'b1) begin
            tick(1);
            n++;
        end
        chk("pp_found_done", int'(n < 100), 1);
        chk("pp_count_before", int'(o_FIFO_COUNT), 1);
        push(8'h77, 1'b1);
        chk("pp_count_after", int'(o_FIFO_COUNT), 1);
        chk("pp_next_start", int'(o_SERIAL_DATA), 0);
        wait_idle("pp");
        chk("pp_frames", frames - f0, 3);

        // Reset in the middle of data bit 3 of 0x52
        push(8'h52, 1'b1);
        push(8'hC3, 1'b1);
        tick(17);
        chk("mid_line_bit3", int'(o_SERIAL_DATA), 0);
        chk("mid_count", int'(o_FIFO_COUNT), 1);
        d0 = done_cnt;
        i_RESET = 1'b1;
        sb.delete();
        tick(1);
        chk("mid_rst_line", int'(o_SERIAL_DATA), 1);
        chk("mid_rst_count", int'(o_FIFO_COUNT), 0);
        chk("mid_rst_active", int'(o_TX_ACTIVE), 0);
        tick(1);
        i_RESET = 1'b0;
        tick(60);
        chk("mid_no_done", done_cnt - d0, 0);
        f0 = frames;
        push(8'h96, 1'b1);
        wait_idle("after_rst");
        chk("after_rst_frames", frames - f0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
